// File: rtl/riscv_pkg.sv
// Shared constants, types and decode helpers for the RISC-V front end.
// Consumed by fetch_stage and fetch_pc_gen.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [6:0]  OPCODE_BRANCH    = 7'b1100011;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SEQ      = 2'd0,
        PC_HOLD     = 2'd1,
        PC_REDIRECT = 2'd2,
        PC_PREDICT  = 2'd3
    } pc_sel_t;

    // Sign-extended B-type branch offset; bit 0 is always zero.
    function automatic logic [31:0] b_imm(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Combinational next-PC selection: redirect, hold, sequential, or predicted.
// Static backward-taken prediction is compiled in with BTFN_PREDICT_EN.
module fetch_pc_gen
    import riscv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        redirect,
    input  logic [29:0] redirect_word,
    input  logic        halt,
    input  logic        stall,
`ifdef BTFN_PREDICT_EN
    input  logic [31:0] instr,
`endif
    output logic [31:0] next_pc,
    output logic        pred_taken
);

    pc_sel_t     sel;
    logic [31:0] seq_pc;

    assign seq_pc = pc + 32'd4;

`ifdef BTFN_PREDICT_EN
    logic back_branch;
    assign back_branch = (instr[6:0] == OPCODE_BRANCH) && instr[31];
`endif

    // Source priority: redirect beats any hold; out-of-range halt and stall both freeze pc.
    always_comb begin
        sel = PC_SEQ;
        if (redirect) begin
            sel = PC_REDIRECT;
        end else if (halt || stall) begin
            sel = PC_HOLD;
`ifdef BTFN_PREDICT_EN
        end else if (back_branch) begin
            sel = PC_PREDICT;
`endif
        end else begin
            sel = PC_SEQ;
        end
    end

    // Map the selected source onto the next PC and prediction flag.
    always_comb begin
        next_pc    = seq_pc;
        pred_taken = 1'b0;
        case (sel)
            PC_REDIRECT: next_pc = {redirect_word, 2'b00};
            PC_HOLD:     next_pc = pc;
`ifdef BTFN_PREDICT_EN
            PC_PREDICT: begin
                next_pc    = pc + b_imm(instr);
                pred_taken = 1'b1;
            end
`endif
            default: begin
                next_pc    = seq_pc;
                pred_taken = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// PC register and IF/ID pipeline register with stall, redirect and out-of-range halt.
// Optional static prediction: define BTFN_PREDICT_EN.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          IMEM_DEPTH = 32
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic        ifid_pred_taken,
    output logic        fetch_misaligned,
    output logic        fetch_oob
);

    localparam logic [31:0] DEPTH_WORDS = 32'(IMEM_DEPTH);

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        pred_taken;
    logic        pc_oob;
    logic        target_oob;
    logic        halt;

    assign imem_addr  = pc;
    assign pc_oob     = {2'b00, pc[31:2]} >= DEPTH_WORDS;
    assign target_oob = {2'b00, redirect_pc[31:2]} >= DEPTH_WORDS;
    // Once halted, the sticky flag keeps fetch frozen even though pc itself is unchanged.
    assign halt       = fetch_oob | pc_oob;

    fetch_pc_gen u_pc_gen (
        .pc            (pc),
        .redirect      (redirect),
        .redirect_word (redirect_pc[31:2]),
        .halt          (halt),
        .stall         (stall),
`ifdef BTFN_PREDICT_EN
        .instr         (imem_instr),
`endif
        .next_pc       (next_pc),
        .pred_taken    (pred_taken)
    );

    // PC and IF/ID registers: reset > redirect > halt > stall > fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc               <= RESET_PC;
            ifid_valid       <= 1'b0;
            ifid_instr       <= NOP_INSTR;
            ifid_pc          <= 32'h0000_0000;
            ifid_pred_taken  <= 1'b0;
            fetch_misaligned <= 1'b0;
            fetch_oob        <= 1'b0;
        end else if (redirect) begin
            pc               <= next_pc;
            ifid_valid       <= 1'b0;
            ifid_instr       <= NOP_INSTR;
            ifid_pred_taken  <= 1'b0;
            fetch_misaligned <= (redirect_pc[1:0] != 2'b00);
            fetch_oob        <= fetch_oob & target_oob;
        end else if (halt) begin
            pc               <= next_pc;
            ifid_valid       <= 1'b0;
            ifid_instr       <= NOP_INSTR;
            ifid_pred_taken  <= 1'b0;
            fetch_misaligned <= 1'b0;
            fetch_oob        <= 1'b1;
        end else if (stall) begin
            fetch_misaligned <= 1'b0;
        end else begin
            pc               <= next_pc;
            ifid_valid       <= 1'b1;
            ifid_instr       <= imem_instr;
            ifid_pc          <= pc;
            ifid_pred_taken  <= pred_taken;
            fetch_misaligned <= 1'b0;
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Program-counter and IF/ID pipeline-register stage feeding the word-addressed, combinational-read instruction memory.
- Drives imem_addr from the PC and captures the returned instruction, with its PC, into the IF/ID register consumed by decode.
- Handles stall from the hazard unit, redirect/flush from execute, and an out-of-range fetch halt.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- IMEM_DEPTH, 32: instruction memory depth in 32-bit words; the valid fetch range is word index 0..IMEM_DEPTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID (hazard unit).
- redirect  in  1  taken branch/jump or mispredict from execute; flushes IF/ID.
- redirect_pc  in  32  target PC accompanying redirect.
- imem_addr  out  32  byte address to instruction memory; always equals pc.
- imem_instr  in  32  instruction word returned combinationally for imem_addr.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  32  captured instruction.
- ifid_pc  out  32  PC of the captured instruction.
- ifid_pred_taken  out  1  fetch predicted this instruction taken.
- fetch_misaligned  out  1  one-cycle pulse: redirect_pc[1:0] was nonzero.
- fetch_oob  out  1  sticky: PC left the memory range; fetch halted.

Behaviour:
- All state updates on the rising clk edge. Priority order: reset > redirect > fetch_oob halt > stall > normal fetch.
- Reset values:
  - pc = RESET_PC
  - ifid_valid = 0
  - ifid_instr = 32'h0000_0013 (NOP)
  - ifid_pc = 0
  - ifid_pred_taken = 0
  - fetch_misaligned = 0
  - fetch_oob = 0
- Reset asserted mid-stall or mid-redirect overrides both.
- Normal fetch (no stall, no redirect, not oob):
  - ifid_instr <= imem_instr; ifid_pc <= pc; ifid_valid <= 1
  - pc <= pc + 4, wrapping modulo 2^32
  - Latency: instruction fetched at PC p appears on ifid_* one cycle after pc = p.
- Stall (no redirect): pc and every ifid_* output hold their values. Stall may last any number of cycles.
- Redirect (wins over a simultaneous stall):
  - pc <= {redirect_pc[31:2], 2'b00}
  - ifid_valid <= 0; ifid_instr <= NOP; ifid_pred_taken <= 0
  - fetch_misaligned <= (redirect_pc[1:0] != 0); it deasserts the next cycle unless re-triggered.
- Out of range: when pc[31:2] >= IMEM_DEPTH and no redirect:
  - fetch_oob <= 1; pc holds; ifid_valid <= 0; ifid_instr <= NOP
  - fetch_oob clears only on reset or on a redirect to an in-range target.
  - imem_instr is ignored while fetch_oob is set.
- fetch_oob blocks the stall path: stall during oob still produces NOP bubbles.

Optional Feature:
- Macro BTFN_PREDICT_EN.
- When defined, during a normal fetch where imem_instr[6:0] == 7'b1100011 and imem_instr[31] == 1 (backward conditional branch):
  - pc <= pc + sext(B-immediate); ifid_pred_taken <= 1
  - Execute issues redirect to pc+4 on a mispredict.
- Forward branches and non-branches: pc + 4, ifid_pred_taken <= 0.
- When undefined: ifid_pred_taken is constant 0 and next PC is always pc + 4.

Decomposition:
- Shared package riscv_pkg holds:
  - NOP_INSTR = 32'h0000_0013
  - OPCODE_BRANCH = 7'b1100011
  - default RESET_PC
  - function b_imm(instr) returning the 32-bit sign-extended B-type offset.
- One natural sub-module, fetch_pc_gen: combinational next-PC selection (redirect / hold / sequential / predicted).
- The PC and IF/ID registers stay in fetch_stage.

Test Plan:
- Reset then 3 free-running cycles with memory words 0x00500093, 0x00600113, 0x002081B3:
  - ifid_pc = 0, 4, 8 on consecutive cycles with matching instructions; ifid_valid = 1 from cycle 1.
- Stall high for 2 cycles at pc = 8:
  - pc stays 8; ifid_pc = 4 and ifid_instr = 0x00600113 held.
  - Fetch resumes at 8 after release.
- Redirect to 0x10 while stall = 1:
  - next cycle pc = 0x10, ifid_valid = 0, ifid_instr = 0x00000013.
  - Following cycle ifid_pc = 0x10, ifid_valid = 1.
- Redirect to 0x0E:
  - pc = 0x0C, fetch_misaligned = 1 for exactly one cycle.
- IMEM_DEPTH = 4, free run from 0:
  - after ifid_pc = 0xC, fetch_oob = 1 with pc held at 0x10; ifid_valid stays 0.
  - Redirect to 0x4 clears fetch_oob.
- With BTFN_PREDICT_EN, word at 0x8 = 0xFE000CE3 (beq x0,x0,-8):
  - next pc = 0x0; ifid_pred_taken = 1 with ifid_pc = 0x8.
- Without BTFN_PREDICT_EN, same word:
  - next pc = 0xC; ifid_pred_taken = 0.
